// File: rtl/sram_responder.sv
// SRAM-like slave: word memory plus MMIO timer/scratch/status window, with a fixed 1-cycle read latency.
// Accepts a request every cycle (no backpressure). rdata changes only on read edges and holds otherwise.
module sram_responder #(
  parameter int          AW        = 14,
  parameter logic [31:0] MMIO_BASE = 32'h1FAF_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        err_flag
);

  localparam logic [29:0] TMR_WORD = MMIO_BASE[31:2];
  localparam logic [29:0] SCR_WORD = TMR_WORD + 30'd1;
  localparam logic [29:0] STS_WORD = TMR_WORD + 30'd2;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic [31:0]   timer;
  logic [31:0]   scratch;
  logic          err;

  logic [31:0]   phys;
  logic [AW-1:0] idx;
  logic          is_mem, is_tmr, is_scr, is_sts, dec_err;
  logic          rd, wr;
  logic [31:0]   wmask;
  logic [31:0]   timer_nxt;
  logic [31:0]   rd_val;
  logic          unused_addr_bits;

  // Top three bits drop kseg0/kseg1 aliasing; byte offset is ignored (lanes come from wen).
  assign phys   = {3'b000, addr[28:0]};
  assign idx    = phys[AW+1:2];
  assign is_mem = (phys[31:AW+2] == '0);
  assign is_tmr = (phys[31:2] == TMR_WORD);
  assign is_scr = (phys[31:2] == SCR_WORD);
  assign is_sts = (phys[31:2] == STS_WORD);
  assign dec_err = !(is_mem || is_tmr || is_scr || is_sts);

  assign rd    = en && (wen == 4'h0);
  assign wr    = en && (wen != 4'h0);
  assign wmask = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};

  assign unused_addr_bits = ^{addr[31:29], addr[1:0]};

  // A timer write replaces lanes of the incremented value, not of the current one.
  always_comb begin
    timer_nxt = timer + 32'd1;
    if (wr && is_tmr)
      timer_nxt = (timer_nxt & ~wmask) | (wdata & wmask);
  end

  always_comb begin
    rd_val = 32'h0;
    if (is_mem)      rd_val = mem[idx];
    else if (is_tmr) rd_val = timer;
    else if (is_scr) rd_val = scratch;
    else if (is_sts) rd_val = {31'h0, err};
  end

  always_ff @(posedge clk) begin
    if (resetn && wr && is_mem) begin
      for (int i = 0; i < 4; i++)
        if (wen[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata   <= 32'h0;
      timer   <= 32'h0;
      scratch <= 32'h0;
      err     <= 1'b0;
    end else begin
      timer <= timer_nxt;
      if (rd)
        rdata <= rd_val;
      if (wr && is_scr)
        scratch <= (scratch & ~wmask) | (wdata & wmask);
      // Set wins over W1C clear.
      if (en && dec_err)
        err <= 1'b1;
      else if (wr && is_sts && wen[0] && wdata[0])
        err <= 1'b0;
    end
  end

  assign err_flag = err;

endmodule

// File: tb/tb_sram_responder.sv
// Randomised and directed bench for sram_responder against an address-decoded reference model.
module tb_sram_responder;

  localparam int          AW        = 14;
  localparam logic [31:0] MMIO_BASE = 32'h1FAF_0000;
  localparam logic [31:0] MEM_BYTES = 32'h1 << (AW + 2);

  logic        clk;
  logic        resetn;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        err_flag;

  int n_chk = 0;
  int n_err = 0;

  // Reference state
  logic [31:0] mem_m [int unsigned];
  logic [31:0] timer_m, scratch_m, rd_m;
  logic        err_m;

  sram_responder #(.AW(AW), .MMIO_BASE(MMIO_BASE)) dut (
    .clk(clk), .resetn(resetn), .en(en), .wen(wen), .addr(addr),
    .wdata(wdata), .rdata(rdata), .err_flag(err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] w);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (w[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    timer_m = 0; scratch_m = 0; rd_m = 0; err_m = 0;
  endtask

  // One clock edge of the specified behaviour, applied after the edge is seen.
  task automatic model_step(input logic e, input logic [3:0] w, input logic [31:0] a,
                            input logic [31:0] d);
    logic [31:0] phys, t_old, word;
    phys  = a & 32'h1FFF_FFFF;
    word  = phys >> 2;
    t_old = timer_m;
    timer_m = t_old + 1;
    if (!e) return;
    if (phys < MEM_BYTES) begin
      if (w == 0) rd_m = mem_m.exists(word) ? mem_m[word] : 32'hx;
      else mem_m[word] = merge(mem_m.exists(word) ? mem_m[word] : 32'h0, d, w);
    end else if (word == (MMIO_BASE >> 2)) begin
      if (w == 0) rd_m = t_old;
      else timer_m = merge(t_old + 1, d, w);
    end else if (word == (MMIO_BASE >> 2) + 1) begin
      if (w == 0) rd_m = scratch_m;
      else scratch_m = merge(scratch_m, d, w);
    end else if (word == (MMIO_BASE >> 2) + 2) begin
      if (w == 0) rd_m = {31'h0, err_m};
      else if (w[0] && d[0]) err_m = 1'b0;
    end else begin
      if (w == 0) rd_m = 32'h0;
      err_m = 1'b1;
    end
  endtask

  // Drive at negedge, let the DUT take the edge, compare on the following negedge.
  task automatic op(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
    @(posedge clk);
    model_step(e, w, a, d);
    @(negedge clk);
    check("rdata", rdata, rd_m);
    check("err_flag", {31'h0, err_flag}, {31'h0, err_m});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  w;
    int          sel;

    resetn = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_err", {31'h0, err_flag}, 32'h0);

    // Timer counts edges since release: one idle edge, then the read sees 1.
    idle(1);
    op(1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
    check("timer_first", rdata, 32'h1);

    // Byte lanes, kseg0 write / kseg1 read alias
    op(1'b1, 4'hF, 32'h8000_0100, 32'hAABB_CCDD);
    op(1'b1, 4'b0101, 32'h8000_0100, 32'h1122_3344);
    op(1'b1, 4'h0, 32'hA000_0102, 32'h0);
    check("byte_lanes", rdata, 32'hAA22_CC44);

    // Back-to-back write then read, held through idle
    op(1'b1, 4'hF, 32'h0000_0000, 32'h1234_5678);
    op(1'b1, 4'h0, 32'h0000_0000, 32'h0);
    check("raw_read", rdata, 32'h1234_5678);
    idle(5);
    check("raw_hold", rdata, 32'h1234_5678);
    // A write must not disturb rdata
    op(1'b1, 4'hF, 32'h0000_0004, 32'hDEAD_BEEF);
    check("write_no_rdata", rdata, 32'h1234_5678);

    // Timer overwrite and wrap
    op(1'b1, 4'hF, 32'hBFAF_0000, 32'hFFFF_FFFE);
    op(1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
    check("timer_load", rdata, 32'hFFFF_FFFE);
    idle(1);
    op(1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
    check("timer_wrap", rdata, 32'h0);

    // Decode error, W1C, and write-0 leaving err set
    op(1'b1, 4'h0, MEM_BYTES, 32'h0);
    check("decerr_rdata", rdata, 32'h0);
    check("decerr_set", {31'h0, err_flag}, 32'h1);
    op(1'b1, 4'h0, MMIO_BASE + 32'h8, 32'h0);
    check("status_read", rdata, 32'h1);
    op(1'b1, 4'h1, MMIO_BASE + 32'h8, 32'h1);
    check("w1c_clear", {31'h0, err_flag}, 32'h0);
    op(1'b1, 4'hF, MMIO_BASE + 32'hC, 32'h5555_5555);
    check("decerr_write_set", {31'h0, err_flag}, 32'h1);
    op(1'b1, 4'hF, MMIO_BASE + 32'h8, 32'h0);
    check("w0_keeps_err", {31'h0, err_flag}, 32'h1);

    // Scratch lane write
    op(1'b1, 4'b1100, MMIO_BASE + 32'h4, 32'hCAFE_0000);
    op(1'b1, 4'h0, MMIO_BASE + 32'h4, 32'h0);
    check("scratch", rdata, 32'hCAFE_0000);

    // Async reset half a cycle after a read edge
    op(1'b1, 4'h0, 32'h8000_0100, 32'h0);
    resetn = 1'b0;
    en = 1'b0; wen = 4'h0;
    #1;
    check("async_rdata", rdata, 32'h0);
    check("async_err", {31'h0, err_flag}, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    op(1'b1, 4'h0, 32'h8000_0100, 32'h0);
    check("mem_survives_reset", rdata, 32'hAA22_CC44);

    // Initialise the random working set of memory words
    for (int i = 0; i < 16; i++) op(1'b1, 4'hF, i * 4, $urandom);

    for (int n = 0; n < 500; n++) begin
      sel = $urandom_range(0, 9);
      d   = $urandom;
      w   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (sel < 6)       a = {3'($urandom), 29'($urandom_range(0, 15) * 4)};
      else if (sel < 9)  a = {3'($urandom), MMIO_BASE[28:0] + 29'($urandom_range(0, 3) * 4)};
      else               a = {3'($urandom), MEM_BYTES[28:0] + 29'($urandom_range(0, 255) * 4)};
      a[1:0] = 2'($urandom);
      op(1'($urandom_range(0, 3) != 0), w, a, d);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Slave end of the core's SRAM-like port: serves en/wen/addr/wdata requests and returns rdata one cycle later, matching the fixed 1-cycle read latency the core's inst_sram and data_sram ports expect.
- Backs a word-organised memory of 2^AW words plus a small MMIO window: free-running timer, scratch register, sticky decode-error status.
- One instance per core port (instruction side and data side) in the SoC top.

Parameters:
- AW, 14, word-address width of the backing memory (2^AW words, 64 KB at default).
- MMIO_BASE, 32'h1FAF_0000, physical base of the 16-byte MMIO window.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- resetn  input  1  reset, asynchronous, active-low
- en  input  1  request valid this cycle
- wen  input  4  byte-lane write enables; 0 with en=1 means read
- addr  input  32  byte address (virtual, kseg-style)
- wdata  input  32  write data, lane i = wdata[8i+7:8i]
- rdata  output  32  registered read data
- err_flag  output  1  sticky decode-error flag (mirrors status bit0)

Behaviour:
- Reset (resetn=0, async): rdata=0, err_flag=0, timer=0, scratch=0. Memory array is not reset (contents undefined until written).
- Address translation: phys = {3'b000, addr[28:0]}; addr[1:0] ignored (word access, lanes via wen).
- Decode, evaluated on phys:
  - phys < 2^(AW+2) -> memory, index phys[AW+1:2].
  - phys == MMIO_BASE+0x0 -> timer.
  - phys == MMIO_BASE+0x4 -> scratch.
  - phys == MMIO_BASE+0x8 -> status (bit0 = err, bits 31:1 read 0).
  - MMIO_BASE+0xC and anything else -> decode error.
- Read (en=1, wen=0): rdata is updated at the same edge and is valid the whole following cycle. Memory returns stored word; MMIO returns the register value before this edge's update; decode error returns 32'h0.
- rdata holds its value in any cycle with en=0 or wen!=0. Writes never change rdata.
- Write (en=1, wen!=0): only enabled lanes are updated at the edge.
  - Memory: lane-masked write.
  - Scratch: lane-masked write.
  - Timer: next = (timer+1) with enabled lanes replaced by wdata lanes.
  - Status: if wen[0] and wdata[0]=1, err is cleared (W1C); other bits ignored.
  - Decode error: write dropped.
- Any decode-error access (read or write) sets err at that edge.
- Read-after-write: a write at edge N followed by a read of the same word at edge N+1 returns the new data at N+1.
- Timer: increments by 1 every cycle except lanes overwritten as above. Wraps 32'hFFFF_FFFF -> 0 silently.
- Simultaneous set/clear: a decode error cannot coincide with a status write on a single port, so W1C is the only clear path. Set takes priority if both are ever asserted.
- en=0: no state change except the timer increment.
- Reset mid-operation: asserting resetn low aborts any pending read. rdata returns to 0 immediately (async). A write that has not reached the edge is not performed.

Test Plan:
- Reset: hold resetn=0 for 3 cycles, release -> rdata=0, err_flag=0; read MMIO_BASE+0x0 on the first cycle after release -> rdata=1 or 2, consistent with the cycle count since reset release.
- Byte-lane write: write 32'hAABBCCDD to 0x8000_0100 with wen=4'hF, then wdata=32'h1122_3344 with wen=4'b0101, then read 0xA000_0100 -> rdata=32'hAA22_CC44 one cycle after the read request (kseg0/kseg1 alias the same word).
- Back-to-back: write 32'h1234_5678 to 0x0 at edge N, read 0x0 at edge N+1 -> rdata=32'h1234_5678 during cycle N+1 and held through 5 idle cycles.
- Timer: write 32'hFFFF_FFFE to timer with wen=4'hF, read it on the next cycle -> rdata=32'hFFFF_FFFE; read again 2 cycles later -> rdata=32'h0000_0000 (wrap).
- Decode error: read phys 2^(AW+2) (0x0001_0000 at default) -> rdata=0, err_flag=1 from the next cycle. Write 32'h1 with wen=4'h1 to status -> err_flag=0. Write 32'h0 to status -> err_flag stays set if an error precedes it.
- Async reset mid-read: assert resetn low half a cycle after a read edge -> rdata=0 immediately. After release, memory contents written before the reset are still readable.
